// File: rtl/jump_encoder.sv
// Encodes MIPS J/JAL instruction words from a byte target, with alignment and 256 MB region checks.
// Three-state handshake FSM (IDLE -> CALC -> OUT) with saturating success/error counters.
module jump_encoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] pc,
    input  logic [31:0] target,
    input  logic        link,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err_align,
    output logic        err_region,
    output logic [15:0] enc_count,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [5:0]  OPCODE_J   = 6'b000010;
    localparam logic [5:0]  OPCODE_JAL = 6'b000011;
    localparam logic [15:0] COUNT_MAX  = 16'hFFFF;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        link_q, link_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] instr_q, instr_d;
    logic        err_align_q, err_align_d;
    logic        err_region_q, err_region_d;
    logic [15:0] enc_count_q, enc_count_d;
    logic [15:0] err_count_q, err_count_d;

    logic [31:0] pc_plus4;
    logic [3:0]  region;
    logic        misaligned;
    logic        off_region;
    logic [5:0]  opcode;
    logic        pc_plus4_low_unused;

    // The region is taken from the delay-slot address, so pc = FFFF_FFFC wraps into region 0.
    assign pc_plus4            = pc_q + 32'd4;
    assign region              = pc_plus4[31:28];
    assign pc_plus4_low_unused = ^pc_plus4[27:0];

    assign misaligned = (target_q[1:0] != 2'b00);
    assign off_region = (target_q[31:28] != region);
    assign opcode     = link_q ? OPCODE_JAL : OPCODE_J;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        link_d       = link_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        instr_d      = instr_q;
        err_align_d  = err_align_q;
        err_region_d = err_region_q;
        enc_count_d  = enc_count_q;
        err_count_d  = err_count_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pc_d       = pc;
                    target_d   = target;
                    link_d     = link;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end

            CALC: begin
                err_align_d  = misaligned;
                err_region_d = off_region;
                if (misaligned || off_region) begin
                    instr_d = 32'h0000_0000;
                end else begin
                    instr_d = {opcode, target_q[27:2]};
                end
                out_valid_d = 1'b1;
                state_d     = OUT;
            end

            OUT: begin
                // Results and counters only move on the consumer handshake.
                if (out_ready) begin
                    if (!err_align_q && !err_region_q) begin
                        if (enc_count_q != COUNT_MAX) begin
                            enc_count_d = enc_count_q + 16'd1;
                        end
                    end else begin
                        if (err_count_q != COUNT_MAX) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                    end
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= 32'h0000_0000;
            target_q     <= 32'h0000_0000;
            link_q       <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            instr_q      <= 32'h0000_0000;
            err_align_q  <= 1'b0;
            err_region_q <= 1'b0;
            enc_count_q  <= 16'h0000;
            err_count_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            link_q       <= link_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            instr_q      <= instr_d;
            err_align_q  <= err_align_d;
            err_region_q <= err_region_d;
            enc_count_q  <= enc_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign instr      = instr_q;
    assign err_align  = err_align_q;
    assign err_region = err_region_q;
    assign enc_count  = enc_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_jump_encoder.sv
// Directed and randomized bench for jump_encoder, checked against an arithmetic reference model.
module tb_jump_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] target;
    logic        link;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err_align;
    logic        err_region;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    int vectors     = 0;
    int miscompares = 0;
    int model_enc   = 0;
    int model_err   = 0;

    always #5 clk = ~clk;

    jump_encoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pc         (pc),
        .target     (target),
        .link       (link),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr      (instr),
        .err_align  (err_align),
        .err_region (err_region),
        .enc_count  (enc_count),
        .err_count  (err_count)
    );

    // Reference result packed as {err_align, err_region, instr}, from plain integer arithmetic.
    function automatic logic [33:0] modelEncode(input logic [31:0] p, input logic [31:0] t, input logic l);
        longint next_pc;
        longint pc_region;
        longint tgt_region;
        longint word;
        bit     ea;
        bit     er;
        next_pc    = (longint'(p) + 64'd4) % 64'h1_0000_0000;
        pc_region  = next_pc / 64'h1000_0000;
        tgt_region = longint'(t) / 64'h1000_0000;
        ea         = (longint'(t) % 64'd4) != 0;
        er         = (tgt_region != pc_region);
        if (ea || er) begin
            word = 0;
        end else begin
            word = (l ? 64'd3 : 64'd2) * 64'h0400_0000 + (longint'(t) % 64'h1000_0000) / 64'd4;
        end
        return {ea, er, word[31:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleCounters(input string tag);
        checkOutput({tag, "_enc_count"}, 32'(enc_count), 32'(model_enc));
        checkOutput({tag, "_err_count"}, 32'(err_count), 32'(model_err));
    endtask

    // Called at a falling edge with the block idle; returns at a falling edge with it idle again.
    task automatic applyStimulus(input logic [31:0] p, input logic [31:0] t, input logic l, input int hold);
        logic [33:0] exp;
        exp = modelEncode(p, t, l);

        pc        = p;
        target    = t;
        link      = l;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);

        @(negedge clk);
        in_valid = 1'b0;
        pc       = $urandom;
        target   = $urandom;
        link     = 1'($urandom);
        checkOutput("in_ready_calc", 32'(in_ready), 32'd0);
        checkOutput("out_valid_calc", 32'(out_valid), 32'd0);

        @(negedge clk);
        checkOutput("out_valid", 32'(out_valid), 32'd1);
        checkOutput("instr", instr, exp[31:0]);
        checkOutput("err_align", 32'(err_align), 32'(exp[33]));
        checkOutput("err_region", 32'(err_region), 32'(exp[32]));

        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0);
            pc       = $urandom;
            target   = $urandom;
            @(negedge clk);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_instr", instr, exp[31:0]);
            checkOutput("bp_flags", 32'({err_align, err_region}), 32'(exp[33:32]));
            checkIdleCounters("bp");
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (exp[33:32] == 2'b00) begin
            model_enc = (model_enc < 65535) ? model_enc + 1 : 65535;
        end else begin
            model_err = (model_err < 65535) ? model_err + 1 : 65535;
        end
        checkOutput("done_out_valid", 32'(out_valid), 32'd0);
        checkOutput("done_in_ready", 32'(in_ready), 32'd1);
        checkIdleCounters("done");
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] rtgt;
        logic [31:0] next_pc;

        $display("[TB] starting jump_encoder bench");
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        pc        = 32'h0040_0000;
        target    = 32'h0040_0100;
        link      = 1'b0;
        repeat (3) @(negedge clk);

        // Reset holds the block idle even with a request presented.
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_flags", 32'({err_align, err_region}), 32'd0);
        checkIdleCounters("rst");

        reset_n   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] directed encodings");
        applyStimulus(32'h0040_0000, 32'h0040_0100, 1'b0, 0);
        applyStimulus(32'h1000_0000, 32'h1FFF_FFFC, 1'b1, 0);
        applyStimulus(32'h0040_0000, 32'h0040_0102, 1'b0, 1);
        applyStimulus(32'h0FFF_FFFC, 32'h0000_0000, 1'b1, 0);
        applyStimulus(32'h0040_0000, 32'h0040_0200, 1'b1, 5);
        applyStimulus(32'hFFFF_FFFC, 32'h0000_0010, 1'b0, 0);
        applyStimulus(32'hFFFF_FFFC, 32'h1000_0013, 1'b1, 2);

        $display("[TB] reset in CALC");
        pc       = 32'h0040_0000;
        target   = 32'h0040_0100;
        link     = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        model_enc = 0;
        model_err = 0;
        checkOutput("rst_calc_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_calc_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_calc_instr", instr, 32'd0);
        checkIdleCounters("rst_calc");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_calc_no_output", 32'(out_valid), 32'd0);
        end

        $display("[TB] reset beats handshake in OUT");
        applyStimulus(32'h0040_0000, 32'h0040_0100, 1'b0, 0);
        pc       = 32'h0040_0000;
        target   = 32'h0040_0104;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        reset_n   = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        model_enc = 0;
        model_err = 0;
        checkOutput("rst_out_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_in_ready", 32'(in_ready), 32'd1);
        checkIdleCounters("rst_out");

        $display("[TB] randomized encodings");
        for (int n = 0; n < 40; n++) begin
            rpc     = $urandom;
            next_pc = rpc + 32'd4;
            rtgt    = $urandom;
            if ($urandom_range(3) != 0) rtgt[31:28] = next_pc[31:28];
            if ($urandom_range(3) != 0) rtgt[1:0] = 2'b00;
            applyStimulus(rpc, rtgt, 1'($urandom), int'($urandom_range(3)));
        end

        // Preloading the counters keeps the saturation run short.
        $display("[TB] counter saturation");
        dut.enc_count_q = 16'hFFFD;
        dut.err_count_q = 16'hFFFE;
        model_enc       = 65533;
        model_err       = 65534;
        @(negedge clk);
        checkIdleCounters("preload");
        for (int n = 0; n < 3; n++) begin
            applyStimulus(32'hFFFF_FFFC, 32'h0000_0010, 1'b0, 0);
        end
        for (int n = 0; n < 2; n++) begin
            applyStimulus(32'h0040_0000, 32'h0040_0102, 1'b1, 0);
        end
        checkOutput("sat_enc", 32'(enc_count), 32'h0000_FFFF);
        checkOutput("sat_err", 32'(err_count), 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
